// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the 32-bit-over-16-bit SRAM data-memory path.
package arm_mem_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam int BASE_ADDR_DEFAULT = 1024;
    localparam int DQ_W              = 16;

    // Word index of a byte address; callers truncate to the SRAM word width.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction
endpackage

// File: rtl/sram_phase_counter.sv
// Counts the clocks of one half-access phase and flags the final (and penultimate) cycle.
module sram_phase_counter #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic last_cycle,
    output logic pre_last
);
    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] count;

    assign last_cycle = en && (count == CW'(CYCLES - 1));
    assign pre_last   = en && (count == CW'(CYCLES - 2));

    // Wrapping on last_cycle clears the count for the next phase's entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (!en || last_cycle)
            count <= '0;
        else
            count <= count + 1'b1;
    end
endmodule

// File: rtl/sram_controller.sv
// Splits a 32-bit MEM-stage load/store into two timed 16-bit async-SRAM accesses, low half first.
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int BASE_ADDR     = BASE_ADDR_DEFAULT,
    parameter int SRAM_ADDR_W   = 18,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DQ_W-1:0]        sram_dq_out,
    input  logic [DQ_W-1:0]        sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);
    state_t                 state;
    logic                   is_store;
    logic [SRAM_ADDR_W-2:0] word;
    logic [31:0]            wdata;
    logic [SRAM_ADDR_W-2:0] word_next;
    logic                   last_cycle, pre_last;

    assign word_next = (SRAM_ADDR_W-1)'(word_index(address, 32'(BASE_ADDR)));
    assign ready     = (state == IDLE && !rd_en && !wr_en) || state == DONE;

    sram_phase_counter #(.CYCLES(ACCESS_CYCLES)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .en         (state == LO || state == HI),
        .last_cycle (last_cycle),
        .pre_last   (pre_last)
    );

    // Strobe opens at phase entry and closes one cycle early so address/data hold past we_n rising.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            is_store    <= 1'b0;
            word        <= '0;
            wdata       <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (rd_en || wr_en) begin
                    state       <= LO;
                    is_store    <= wr_en;
                    word        <= word_next;
                    wdata       <= write_data;
                    sram_addr   <= {word_next, 1'b0};
                    sram_dq_out <= write_data[15:0];
                    sram_dq_oe  <= wr_en;
                    sram_we_n   <= !wr_en;
                end
                LO: if (last_cycle) begin
                    state       <= HI;
                    if (!is_store) read_data[15:0] <= sram_dq_in;
                    sram_addr   <= {word, 1'b1};
                    sram_dq_out <= wdata[31:16];
                    sram_we_n   <= !is_store;
                end else if (pre_last) begin
                    sram_we_n   <= 1'b1;
                end
                HI: if (last_cycle) begin
                    state       <= DONE;
                    if (!is_store) read_data[31:16] <= sram_dq_in;
                    sram_dq_oe  <= 1'b0;
                    sram_we_n   <= 1'b1;
                end else if (pre_last) begin
                    sram_we_n   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
